// File: rtl/rx_phase_sync.sv
// Symbol-timing recovery: picks the OS=4 sampling phase with the largest |sample| energy over a
// 2^WIN_LOG2-symbol window and slices bits on that phase. Optional manual override: RX_PHASE_SYNC_MANUAL_EN.
//
// state  | meaning
// IDLE   | receiver disabled or just reset; nothing accumulated
// ACCUM  | adding |i_data| into the energy bin of the current phase
// DECIDE | one cycle: latch the winning phase, clear bins and symbol count
module rx_phase_sync #(
    parameter int NB_INPUT = 8,
    parameter int OS       = 4,
    parameter int WIN_LOG2 = 10,
    parameter int NB_ACC   = 20
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_INPUT-1:0] i_data,
    input  logic                i_valid,
    input  logic                i_enable,
`ifdef RX_PHASE_SYNC_MANUAL_EN
    input  logic                i_manual,
    input  logic [1:0]          i_phase_sel,
`endif
    output logic                o_bit,
    output logic                o_valid,
    output logic [1:0]          o_phase,
    output logic                o_locked
);

    localparam int              NB_MAG     = NB_INPUT - 1;
    localparam int              NB_SUM     = NB_ACC + 1;
    localparam logic [1:0]      LAST_PHASE = 2'(OS - 1);
    localparam logic [WIN_LOG2-1:0] SYM_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            phase_q, cur_phase;
    logic [WIN_LOG2-1:0]   sym_cnt;
    logic [NB_ACC-1:0]     acc [0:3];
    logic                  acc_en, acc_clr, do_decide;
    logic [NB_INPUT-1:0]   data_neg;
    logic [NB_MAG-1:0]     mag;
    logic [NB_SUM-1:0]     acc_sum;
    logic [NB_ACC-1:0]     acc_next;
    logic [1:0]            best_idx;
    logic [NB_ACC-1:0]     best_val;
    logic                  manual_on;
    logic [1:0]            manual_phase;
    logic                  slice_now;

`ifdef RX_PHASE_SYNC_MANUAL_EN
    assign manual_on    = i_manual;
    assign manual_phase = i_phase_sel;
`else
    assign manual_on    = 1'b0;
    assign manual_phase = 2'd0;
`endif

    assign cur_phase = i_valid ? 2'd0 : ((phase_q == LAST_PHASE) ? 2'd0 : phase_q + 2'd1);
    assign slice_now = i_enable && (cur_phase == o_phase);

    // |most-negative| has no positive twin, so it clips to the largest magnitude.
    assign data_neg = ~i_data + NB_INPUT'(1);
    always_comb begin
        mag = i_data[NB_MAG-1:0];
        if (i_data[NB_INPUT-1]) begin
            if (data_neg[NB_INPUT-1]) mag = '1;
            else                      mag = data_neg[NB_MAG-1:0];
        end
    end

    assign acc_sum  = {1'b0, acc[cur_phase]} + NB_SUM'(mag);
    assign acc_next = acc_sum[NB_ACC] ? '1 : acc_sum[NB_ACC-1:0];

    always_comb begin
        best_idx = 2'd0;
        best_val = acc[0];
        for (int i = 1; i < 4; i++) begin
            if (acc[i] > best_val) begin
                best_val = acc[i];
                best_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        do_decide = 1'b0;
        if (!i_enable) begin
            state_d = IDLE;
            acc_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE:   state_d = ACCUM;
                ACCUM: begin
                    acc_en = 1'b1;
                    if (i_valid && (sym_cnt == SYM_LAST)) state_d = DECIDE;
                end
                DECIDE: begin
                    do_decide = 1'b1;
                    acc_clr   = 1'b1;
                    state_d   = ACCUM;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            phase_q <= 2'd0;
            sym_cnt <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            phase_q <= cur_phase;
            if (acc_clr) begin
                sym_cnt <= '0;
                for (int i = 0; i < 4; i++) acc[i] <= '0;
            end else if (acc_en) begin
                acc[cur_phase] <= acc_next;
                if (i_valid) sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    // The slicer compares against the phase held during DECIDE; the new phase applies from the next cycle.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_bit    <= 1'b0;
            o_valid  <= 1'b0;
            o_phase  <= 2'd0;
            o_locked <= 1'b0;
        end else begin
            o_valid <= slice_now;
            if (slice_now) o_bit <= i_data[NB_INPUT-1];

            if (manual_on)      o_phase <= manual_phase;
            else if (do_decide) o_phase <= best_idx;

            if (manual_on)      o_locked <= 1'b1;
            else if (!i_enable) o_locked <= 1'b0;
            else if (do_decide) o_locked <= 1'b1;
        end
    end

endmodule
